// File: rtl/comm_pkg.sv
// comm_pkg: opcodes, acknowledge codes, FSM state type and frame checksum
// shared by the command master and its timer.
package comm_pkg;

    // Command opcodes understood by the copter
    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;

    localparam logic [7:0] POS_ACK   = 8'hA5;

    // Counter widths sized for the largest legal parameter values
    localparam int unsigned IDX_W = 4;  // frame byte index, up to 10 bytes
    localparam int unsigned RXC_W = 3;  // response byte count, up to 4
    localparam int unsigned RTY_W = 2;  // retries left, up to 3

    typedef enum logic [1:0] {
        StIdle,
        StTxByte,
        StTxWait,
        StRxWait
    } state_t;

    // Two's complement of the byte sum, so cmd + data + checksum == 0 mod 256.
    // data is right-aligned; only the low nbytes bytes take part.
    function automatic logic [7:0] frame_chksum(input logic [7:0]  cmd,
                                                input logic [63:0] data,
                                                input int unsigned nbytes);
        logic [7:0] sum;
        sum = cmd;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbytes) sum = sum + data[8*i +: 8];
        end
        return (~sum) + 8'd1;
    endfunction

endpackage

// File: rtl/resp_timer.sv
// resp_timer: counts cycles of rx silence and flags expiry.
// Count width is $clog2(TIMEOUT_CYC); the count saturates at TIMEOUT_CYC-1.
module resp_timer
    import comm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Silence counter: cleared on demand, otherwise counts up while enabled and saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is flagged in the cycle whose increment reaches TIMEOUT_CYC-1, so the
    // master reacts on that same edge (TIMEOUT_CYC-1 cycles after the clear).
    always_comb begin
        expired = en && !clr && (r_cnt >= (LAST - 1'b1));
    end

endmodule

// File: rtl/cmd_master_n.sv
// cmd_master_n: sends a command byte plus DATA_BYTES payload bytes over a byte
// UART and collects a RESP_BYTES response, with timeout and automatic retry.
// Define CMD_MASTER_CHKSUM_EN to append a two's-complement checksum byte.
module cmd_master_n
    import comm_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = 2,
    parameter int unsigned RESP_BYTES  = 1,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned RETRIES     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              cmd,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    send_cmd,
    output logic                    cmd_sent,
    output logic [8*RESP_BYTES-1:0] resp,
    output logic                    resp_rdy,
    input  logic                    clr_resp_rdy,
    output logic                    timeout,
    output logic                    busy,
    output logic [7:0]              tx_data,
    output logic                    trmt,
    input  logic                    tx_done,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic                    clr_rx_rdy
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned RESP_W = 8 * RESP_BYTES;
`ifdef CMD_MASTER_CHKSUM_EN
    localparam int unsigned FRAME_LEN = DATA_BYTES + 2;
`else
    localparam int unsigned FRAME_LEN = DATA_BYTES + 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [RXC_W-1:0] LAST_RX  = RXC_W'(RESP_BYTES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_cmd;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_idx;
    logic [RXC_W-1:0]   r_rx_cnt;
    logic [RTY_W-1:0]   r_retry;
    logic [RESP_W-1:0]  r_shift;
    logic [RESP_W-1:0]  r_resp;
    logic               r_cmd_sent;
    logic               r_resp_rdy;
    logic               r_timeout;

    logic [7:0]         w_tx_byte;
    logic [RESP_W-1:0]  w_shift_next;
    logic               w_start;
    logic               w_tx_last;
    logic               w_rx_byte;
    logic               w_rx_last;
    logic               w_expire;
    logic               w_retry;
    logic               w_giveup;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_tmr_expired;
`ifdef CMD_MASTER_CHKSUM_EN
    logic [7:0]         w_chk;
`endif

    // Frame events decoded from state and handshakes
    always_comb begin
        w_start      = (r_state == StIdle) && send_cmd;
        w_tx_last    = (r_state == StTxWait) && tx_done && (r_idx == LAST_IDX);
        w_rx_byte    = (r_state == StRxWait) && rx_rdy;
        w_rx_last    = w_rx_byte && (r_rx_cnt == LAST_RX);
        // A received byte takes precedence over a coincident expiry
        w_expire     = (r_state == StRxWait) && !rx_rdy && w_tmr_expired;
        w_retry      = w_expire && (r_retry != '0);
        w_giveup     = w_expire && (r_retry == '0);
        w_tmr_en     = (r_state == StRxWait);
        w_tmr_clr    = w_tx_last || w_rx_byte;
        // First response byte ends up in the MSBs
        w_shift_next = (r_shift << 8) | RESP_W'(rx_data);
    end

`ifdef CMD_MASTER_CHKSUM_EN
    assign w_chk = frame_chksum(r_cmd, 64'(r_data), DATA_BYTES);
`endif

    // Frame byte mux: index 0 is the command, then payload MSB byte first
    always_comb begin
        w_tx_byte = r_cmd;
        for (int unsigned i = 1; i <= DATA_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) w_tx_byte = r_data[8*(DATA_BYTES-i) +: 8];
        end
`ifdef CMD_MASTER_CHKSUM_EN
        if (r_idx == IDX_W'(DATA_BYTES + 1)) w_tx_byte = w_chk;
`endif
    end

    resp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_resp_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_tmr_expired)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (send_cmd) w_state_next = StTxByte;
            StTxByte: w_state_next = StTxWait;
            StTxWait: begin
                if (tx_done) w_state_next = (r_idx == LAST_IDX) ? StRxWait : StTxByte;
            end
            StRxWait: begin
                if (w_rx_last)     w_state_next = StIdle;
                else if (w_retry)  w_state_next = StTxByte;
                else if (w_giveup) w_state_next = StIdle;
            end
            default:  w_state_next = StIdle;
        endcase
    end

    // FSM outputs; stray rx bytes outside RX_WAIT are consumed and dropped
    always_comb begin
        trmt       = (r_state == StTxByte);
        busy       = (r_state != StIdle);
        tx_data    = ((r_state == StTxByte) || (r_state == StTxWait)) ? w_tx_byte : 8'h00;
        clr_rx_rdy = rx_rdy && !rst;
    end

    // Frame latch, byte/response counters, retry budget and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd      <= '0;
            r_data     <= '0;
            r_idx      <= '0;
            r_rx_cnt   <= '0;
            r_retry    <= '0;
            r_shift    <= '0;
            r_resp     <= '0;
            r_cmd_sent <= 1'b0;
            r_resp_rdy <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_start) begin
                r_cmd      <= cmd;
                r_data     <= data;
                r_retry    <= RTY_W'(RETRIES);
                r_idx      <= '0;
                r_cmd_sent <= 1'b0;
                r_resp_rdy <= 1'b0;
                r_timeout  <= 1'b0;
            end
            if ((r_state == StTxWait) && tx_done) r_idx <= r_idx + 1'b1;
            if (w_tx_last) begin
                r_cmd_sent <= 1'b1;
                r_rx_cnt   <= '0;
            end
            if (w_rx_byte) begin
                r_shift  <= w_shift_next;
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (clr_resp_rdy) r_resp_rdy <= 1'b0;
            // Set after clear so a coincident completion wins
            if (w_rx_last) begin
                r_resp     <= w_shift_next;
                r_resp_rdy <= 1'b1;
            end
            if (w_retry) begin
                r_retry    <= r_retry - 1'b1;
                r_cmd_sent <= 1'b0;
                r_idx      <= '0;
            end
            if (w_giveup) r_timeout <= 1'b1;
        end
    end

    assign cmd_sent = r_cmd_sent;
    assign resp_rdy = r_resp_rdy;
    assign timeout  = r_timeout;
    assign resp     = r_resp;

endmodule

// File: tb/tb_cmd_master_n.sv
// tb_cmd_master_n: directed checks of cmd_master_n with two instances:
// u_dut_a uses default parameters, u_dut_b is a wide frame with a short timeout.
module tb_cmd_master_n;

`ifdef CMD_MASTER_CHKSUM_EN
    localparam int LEN_A = 4;
    localparam int LEN_B = 6;
`else
    localparam int LEN_A = 3;
    localparam int LEN_B = 5;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A signals
    logic [7:0]  cmd_a, tx_data_a, rx_data_a, resp_a;
    logic [15:0] data_a;
    logic send_a, cmd_sent_a, resp_rdy_a, clr_resp_a, timeout_a, busy_a;
    logic trmt_a, tx_done_a, rx_rdy_a, clr_rx_a;
    // Instance B signals
    logic [7:0]  cmd_b, tx_data_b, rx_data_b;
    logic [31:0] data_b;
    logic [15:0] resp_b;
    logic send_b, cmd_sent_b, resp_rdy_b, clr_resp_b, timeout_b, busy_b;
    logic trmt_b, tx_done_b, rx_rdy_b, clr_rx_b;

    cmd_master_n u_dut_a (
        .clk(clk), .rst(rst), .cmd(cmd_a), .data(data_a), .send_cmd(send_a),
        .cmd_sent(cmd_sent_a), .resp(resp_a), .resp_rdy(resp_rdy_a),
        .clr_resp_rdy(clr_resp_a), .timeout(timeout_a), .busy(busy_a),
        .tx_data(tx_data_a), .trmt(trmt_a), .tx_done(tx_done_a),
        .rx_data(rx_data_a), .rx_rdy(rx_rdy_a), .clr_rx_rdy(clr_rx_a)
    );

    cmd_master_n #(
        .DATA_BYTES(4), .RESP_BYTES(2), .TIMEOUT_CYC(100), .RETRIES(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .cmd(cmd_b), .data(data_b), .send_cmd(send_b),
        .cmd_sent(cmd_sent_b), .resp(resp_b), .resp_rdy(resp_rdy_b),
        .clr_resp_rdy(clr_resp_b), .timeout(timeout_b), .busy(busy_b),
        .tx_data(tx_data_b), .trmt(trmt_b), .tx_done(tx_done_b),
        .rx_data(rx_data_b), .rx_rdy(rx_rdy_b), .clr_rx_rdy(clr_rx_b)
    );

    // UART tx models: log each strobed byte, answer tx_done three cycles later
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int cnt_a = 0;
    int cnt_b = 0;

    always @(negedge clk) begin
        if (rst) begin
            cnt_a = 0; tx_done_a = 1'b0;
            cnt_b = 0; tx_done_b = 1'b0;
        end else begin
            tx_done_a = 1'b0;
            if (cnt_a != 0) begin cnt_a--; if (cnt_a == 0) tx_done_a = 1'b1; end
            if (trmt_a) begin q_a.push_back(tx_data_a); cnt_a = 3; end
            tx_done_b = 1'b0;
            if (cnt_b != 0) begin cnt_b--; if (cnt_b == 0) tx_done_b = 1'b1; end
            if (trmt_b) begin q_b.push_back(tx_data_b); cnt_b = 3; end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rx_a(input logic [7:0] b);
        rx_rdy_a = 1'b1; rx_data_a = b;
        #1 check("clr_rx_rdy_a", clr_rx_a, 1);
        tick();
        rx_rdy_a = 1'b0;
    endtask

    task automatic rx_b(input logic [7:0] b);
        rx_rdy_b = 1'b1; rx_data_b = b;
        #1 check("clr_rx_rdy_b", clr_rx_b, 1);
        tick();
        rx_rdy_b = 1'b0;
    endtask

    task automatic wait_sent_a(input string name);
        for (int k = 0; k < 300 && cmd_sent_a !== 1'b1; k++) tick();
        check(name, cmd_sent_a, 1);
    endtask

    task automatic wait_sent_b(input string name);
        for (int k = 0; k < 300 && cmd_sent_b !== 1'b1; k++) tick();
        check(name, cmd_sent_b, 1);
    endtask

    function automatic logic [7:0] qa(input int i);
        return (i < q_a.size()) ? q_a[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] qb(input int i);
        return (i < q_b.size()) ? q_b[i] : 8'hxx;
    endfunction

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [47:0] bytes;   // expected frame incl. checksum, first byte in MSBs
        logic [7:0]  rx0;
        logic [7:0]  rx1;
        logic [15:0] resp;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a;
        logic [47:0] exp_b;
        int k;

        vecs[0] = '{cmd: 8'h05, data: 32'hDEADBEEF, bytes: 48'h05DEADBEEFC3,
                    rx0: 8'h12, rx1: 8'h34, resp: 16'h1234};
        vecs[1] = '{cmd: 8'h01, data: 32'h00000000, bytes: 48'h0100000000FF,
                    rx0: 8'hA5, rx1: 8'h5A, resp: 16'hA55A};
        vecs[2] = '{cmd: 8'h07, data: 32'h01020304, bytes: 48'h0701020304EF,
                    rx0: 8'h00, rx1: 8'hFF, resp: 16'h00FF};

        rst = 1'b1;
        cmd_a = '0; data_a = '0; send_a = 0; clr_resp_a = 0; rx_data_a = '0; rx_rdy_a = 0;
        cmd_b = '0; data_b = '0; send_b = 0; clr_resp_b = 0; rx_data_b = '0; rx_rdy_b = 0;
        tick(); tick(); tick();

        // Reset values
        check("rst_busy_a", busy_a, 0);
        check("rst_trmt_a", trmt_a, 0);
        check("rst_cmd_sent_a", cmd_sent_a, 0);
        check("rst_resp_rdy_a", resp_rdy_a, 0);
        check("rst_timeout_a", timeout_a, 0);
        check("rst_resp_a", resp_a, 0);
        check("rst_tx_data_a", tx_data_a, 0);
        check("rst_clr_rx_a", clr_rx_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_resp_b", resp_b, 0);
        rst = 1'b0;
        tick();

        // Default frame 05 / 1234, response A5
        cmd_a = 8'h05; data_a = 16'h1234; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        check("first_trmt_a", trmt_a, 1);
        check("first_byte_a", tx_data_a, 8'h05);
        check("busy_a", busy_a, 1);
        wait_sent_a("cmd_sent_a");
        exp_a = 32'h051234B5;
        check("len_a", q_a.size(), LEN_A);
        for (int i = 0; i < LEN_A; i++) check("byte_a", qa(i), exp_a[8*(3-i) +: 8]);
        check("resp_rdy_a_pre", resp_rdy_a, 0);
        rx_a(8'hA5);
        check("resp_rdy_a", resp_rdy_a, 1);
        check("resp_a", resp_a, 8'hA5);
        check("idle_a", busy_a, 0);
        check("no_timeout_a", timeout_a, 0);
        clr_resp_a = 1'b1; tick(); clr_resp_a = 1'b0;
        check("clr_resp_rdy_a", resp_rdy_a, 0);
        check("cmd_sent_hold_a", cmd_sent_a, 1);

        // send_cmd while busy is ignored
        q_a.delete();
        cmd_a = 8'h02; data_a = 16'hABCD; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        check("cmd_sent_cleared_a", cmd_sent_a, 0);
        tick(); tick();
        cmd_a = 8'h07; data_a = 16'hFFFF; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        wait_sent_a("cmd_sent_a2");
        exp_a = 32'h02ABCD86;
        check("len_a2", q_a.size(), LEN_A);
        for (int i = 0; i < LEN_A; i++) check("busy_ignore_byte_a", qa(i), exp_a[8*(3-i) +: 8]);
        rx_a(8'h5A);
        check("resp_a2", resp_a, 8'h5A);
        clr_resp_a = 1'b1; tick(); clr_resp_a = 1'b0;

        // Stray rx byte in IDLE is consumed and dropped
        rx_a(8'h33);
        tick();
        check("stray_resp_a", resp_a, 8'h5A);
        check("stray_resp_rdy_a", resp_rdy_a, 0);
        check("stray_busy_a", busy_a, 0);

        // Table: wide frames on instance B
        for (int v = 0; v < 3; v++) begin
            q_b.delete();
            cmd_b = vecs[v].cmd; data_b = vecs[v].data; send_b = 1'b1;
            tick();
            send_b = 1'b0;
            check("tbl_first_trmt_b", trmt_b, 1);
            wait_sent_b("tbl_cmd_sent_b");
            check("tbl_len_b", q_b.size(), LEN_B);
            for (int i = 0; i < LEN_B; i++)
                check("tbl_byte_b", qb(i), vecs[v].bytes[8*(5-i) +: 8]);
            rx_b(vecs[v].rx0);
            check("tbl_partial_b", resp_rdy_b, 0);
            // Clear coincident with completion: set must win
            clr_resp_b = 1'b1;
            rx_b(vecs[v].rx1);
            clr_resp_b = 1'b0;
            check("tbl_resp_rdy_b", resp_rdy_b, 1);
            check("tbl_resp_b", resp_b, vecs[v].resp);
            check("tbl_timeout_b", timeout_b, 0);
            clr_resp_b = 1'b1; tick(); clr_resp_b = 1'b0;
            check("tbl_clr_b", resp_rdy_b, 0);
        end

        // Retry then timeout with no response
        q_b.delete();
        cmd_b = 8'h03; data_b = 32'h11223344; send_b = 1'b1;
        tick();
        send_b = 1'b0;
        wait_sent_b("retry_sent1_b");
        for (k = 0; k < 200 && trmt_b !== 1'b1; k++) tick();
        check("retry_resend_delay_b", k, 99);
        check("retry_cmd_sent_clr_b", cmd_sent_b, 0);
        wait_sent_b("retry_sent2_b");
        for (k = 0; k < 200 && timeout_b !== 1'b1; k++) tick();
        check("timeout_delay_b", k, 99);
        check("timeout_b", timeout_b, 1);
        check("timeout_resp_rdy_b", resp_rdy_b, 0);
        check("timeout_resp_b", resp_b, 16'h00FF);
        check("timeout_idle_b", busy_b, 0);
        exp_b = 48'h031122334453;
        check("retry_len_b", q_b.size(), 2 * LEN_B);
        for (int i = 0; i < LEN_B; i++) begin
            check("retry_byte1_b", qb(i), exp_b[8*(5-i) +: 8]);
            check("retry_byte2_b", qb(i + LEN_B), exp_b[8*(5-i) +: 8]);
        end

        // Late response: partial byte, one resend, then full response
        q_b.delete();
        cmd_b = 8'h04; data_b = 32'h55667788; send_b = 1'b1;
        tick();
        send_b = 1'b0;
        check("late_timeout_clr_b", timeout_b, 0);
        wait_sent_b("late_sent1_b");
        for (int i = 0; i < 10; i++) tick();
        rx_b(8'h99);
        check("late_partial_b", resp_rdy_b, 0);
        for (k = 0; k < 300 && trmt_b !== 1'b1; k++) tick();
        check("late_resend_b", trmt_b, 1);
        wait_sent_b("late_sent2_b");
        rx_b(8'hAB);
        rx_b(8'hCD);
        check("late_resp_rdy_b", resp_rdy_b, 1);
        check("late_resp_b", resp_b, 16'hABCD);
        check("late_timeout_b", timeout_b, 0);
        for (int i = 0; i < 150; i++) tick();
        check("late_len_b", q_b.size(), 2 * LEN_B);
        check("late_byte_b", qb(LEN_B + 1), 8'h55);
        check("late_no_timeout_b", timeout_b, 0);

        // Reset in the middle of TX_WAIT aborts the frame
        q_a.delete();
        cmd_a = 8'h06; data_a = 16'h0102; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        tick();
        check("abort_in_txwait_a", busy_a && !trmt_a, 1);
        rst = 1'b1;
        #1;
        check("abort_busy_a", busy_a, 0);
        check("abort_trmt_a", trmt_a, 0);
        check("abort_tx_data_a", tx_data_a, 0);
        check("abort_cmd_sent_a", cmd_sent_a, 0);
        check("abort_resp_a", resp_a, 0);
        check("abort_resp_rdy_a", resp_rdy_a, 0);
        check("abort_timeout_a", timeout_a, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("abort_no_trmt_a", q_a.size(), 1);
        check("abort_idle_a", busy_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_master_n.md
# cmd_master_n

Parametrised command master that serialises a command byte plus `DATA_BYTES` payload bytes onto a byte-level UART transmitter and collects a `RESP_BYTES`-byte response. It sits between a host or bench stimulus and the UART byte interface (tx/rx handshake) facing the copter link. Over the current fixed-format master (1 cmd byte, 2 data bytes, 1 resp byte) it adds:

- configurable payload and response lengths;
- a response timeout with automatic retry;
- an optional checksum byte.

## Interface
Parameters:
- `DATA_BYTES`, 2, payload bytes sent after the command byte (1..8)
- `RESP_BYTES`, 1, response bytes collected (1..4)
- `TIMEOUT_CYC`, 1000000, clk cycles of rx silence before a timeout (≥2)
- `RETRIES`, 1, number of automatic frame resends on timeout (0..3)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high (one clock domain; async active-high reset is fixed)
- `cmd`  in  8  command opcode
- `data`  in  8*DATA_BYTES  payload
- `send_cmd`  in  1  start pulse
- `cmd_sent`  out  1  full frame transmitted
- `resp`  out  8*RESP_BYTES  response, first byte received in MSBs
- `resp_rdy`  out  1  response complete
- `clr_resp_rdy`  in  1  knocks down `resp_rdy`
- `timeout`  out  1  all attempts exhausted without a complete response
- `busy`  out  1  high in any state other than IDLE
- `tx_data`  out  8  byte to UART tx
- `trmt`  out  1  one-cycle transmit strobe
- `tx_done`  in  1  UART tx finished the current byte
- `rx_data`  in  8  byte from UART rx
- `rx_rdy`  in  1  UART rx holds a byte
- `clr_rx_rdy`  out  1  one-cycle consume strobe

## Operation
**States:** IDLE → TX_BYTE → TX_WAIT → (TX_BYTE | RX_WAIT) → IDLE.

- **IDLE**
  - `send_cmd` latches `cmd` and `data` into frame registers and loads the retry count to `RETRIES`.
  - The same pulse clears `cmd_sent`, `resp_rdy` and `timeout`, and zeroes the byte index.
- **Frame order:** `cmd`, then `data` MSB byte first, then (with the checksum feature) the checksum.
  - Frame length is L = 1 + DATA_BYTES (+1 with the checksum feature).
- **TX_BYTE:** drives `tx_data` from the byte index, pulses `trmt`, goes to TX_WAIT.
- **TX_WAIT:** on `tx_done`:
  - increments the index;
  - goes back to TX_BYTE if bytes remain;
  - otherwise sets `cmd_sent`, clears the timer and rx byte count, and goes to RX_WAIT.
- **RX_WAIT:** on `rx_rdy`:
  - shifts `rx_data` into the response register;
  - pulses `clr_rx_rdy`;
  - increments the rx count and restarts the timer.
  - When the count reaches RESP_BYTES: drives `resp`, sets `resp_rdy`, goes to IDLE.
- **Timer expiry in RX_WAIT:**
  - Retries remaining: decrement, clear `cmd_sent`, zero the index, resend the whole frame from the latched registers; partial response bytes are discarded.
  - No retries remaining: set `timeout`, go to IDLE. `resp` keeps its previous value and `resp_rdy` stays 0.
- **Ignored and discarded events:**
  - `send_cmd` while busy is ignored.
  - `rx_rdy` outside RX_WAIT: pulse `clr_rx_rdy` and discard the byte.
- **Flag priority:** if `clr_resp_rdy` and the response-complete set occur in the same cycle, the set wins.

## Timing
- **Reset values:**
  - state IDLE;
  - `cmd_sent`, `resp_rdy`, `timeout`, `busy`, `trmt`, `clr_rx_rdy` = 0;
  - `resp` and `tx_data` all zero.
  - Reset mid-frame aborts immediately; no further `trmt`.
- **Transmit:**
  - First `trmt`: the cycle after `send_cmd` is sampled.
  - Each subsequent `trmt`: the cycle after the previous `tx_done`.
- **Completion flags:**
  - `cmd_sent` rises the cycle after the final `tx_done`.
  - `resp_rdy` rises the cycle after the final `rx_rdy` is sampled.
  - Both hold until cleared.
- **Response consume:** `clr_rx_rdy` is asserted in the cycle `rx_rdy` is sampled; the byte is consumed at most once per rx byte.
- **Timeout:** fires when the timer reaches TIMEOUT_CYC-1 with no byte received. The timer counts from the `cmd_sent` cycle or from the last received byte.
- **Timer width:** $clog2(TIMEOUT_CYC); the count saturates and does not wrap.

## Configuration
- **`CMD_MASTER_CHKSUM_EN` defined:**
  - One checksum byte is appended after the data: the 8-bit two's complement of the sum of all frame bytes, so the sum of cmd, data and checksum is 0 mod 256.
  - If the last response byte is not 8'hA5 or 8'h5A, `resp_rdy` still sets and `resp` is delivered unmodified.
- **Undefined:** no checksum byte; frame length is 1 + DATA_BYTES.

## Structure
- **Shared package `comm_pkg`:**
  - command opcodes (REQ_BATT … EMER_LAND);
  - POS_ACK 8'hA5;
  - the state enum type;
  - the checksum function.
- **Sub-module `resp_timer`:** parametrised by TIMEOUT_CYC, with `clr` and `en` inputs and an `expired` output.

## Test plan
- **Default frame:** cmd 8'h05, data 16'h1234, default parameters.
  - Expect `trmt` bytes 05, 12, 34, then `cmd_sent`.
  - UART model returns A5: `resp` = 8'hA5 and `resp_rdy` = 1 one cycle later.
- **Wide frame:** DATA_BYTES=4, RESP_BYTES=2, data 32'hDEADBEEF.
  - Expect bytes cmd, DE, AD, BE, EF.
  - Response 12, 34 gives `resp` = 16'h1234.
- **Retry:** RETRIES=1, TIMEOUT_CYC=100, no response.
  - Expect two identical frames; `timeout` = 1 99 cycles after the second `cmd_sent`; `resp_rdy` = 0.
- **Late response:** response arrives only after one timeout → exactly one resend, then `resp_rdy` = 1 and `timeout` = 0.
- **Checksum:** `CMD_MASTER_CHKSUM_EN` defined, cmd 01, data 0000 → byte 4 = 8'hFF.
- **Abort and discard cases:**
  - `rst` pulse mid-TX_WAIT → all outputs zero next cycle.
  - `send_cmd` while busy → no effect.
  - Stray `rx_rdy` in IDLE → `clr_rx_rdy` pulse, `resp` unchanged.
